// File: rtl/prll_bs_drvr_endpoint.sv
// Purpose: driver-side endpoint of the 8-driver parallel bus; TX FIFO feeds the arbiter, RX FIFO feeds the node.
// Latency: node write to pndng/D_pop is 1 cycle; arbiter push to rx_vld/rx_data is 1 cycle.
// Backpressure: tx_rdy drops when TX is full; RX pushes into a full FIFO are dropped and flagged in rx_ovrflw.
//
// Ports: clk/reset (sync, active-high); tx_vld/tx_rdy/tx_data node->TX; pndng/pop/D_pop TX->arbiter;
//        push/D_push arbiter->RX; rx_vld/rx_rdy/rx_data RX->node; tx_cnt/rx_cnt occupancy;
//        rx_ovrflw/pop_err sticky error flags.
// Optional feature: define PRLL_BS_RX_ID_FILTER_EN to accept only pushes addressed to `id` or `broadcast`.

module prll_bs_fifo #(
  parameter int bits  = 256,
  parameter int depth = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr,
  input  logic [bits-1:0]          wr_data,
  input  logic                     rd,
  output logic [bits-1:0]          head,
  output logic [$clog2(depth):0]   cnt
);
  localparam int aw = $clog2(depth);

  logic [bits-1:0] mem [depth];
  logic [aw-1:0]   wr_ptr;
  logic [aw-1:0]   rd_ptr;

  // Pointers wrap naturally since depth is a power of two; the extra count
  // bit distinguishes full from empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, rd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= wr_data;
  end

  // Show-ahead head, zeroed while empty so stale entries never leak out.
  assign head = (cnt == '0) ? '0 : mem[rd_ptr];
endmodule

module prll_bs_drvr_endpoint #(
  parameter int         bits      = 256,
  parameter int         depth     = 16,
  parameter logic [7:0] id        = 8'd0,
  parameter logic [7:0] broadcast = {8{1'b1}}
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tx_vld,
  output logic                     tx_rdy,
  input  logic [bits-1:0]          tx_data,
  output logic                     pndng,
  input  logic                     pop,
  output logic [bits-1:0]          D_pop,
  input  logic                     push,
  input  logic [bits-1:0]          D_push,
  output logic                     rx_vld,
  input  logic                     rx_rdy,
  output logic [bits-1:0]          rx_data,
  output logic [$clog2(depth):0]   tx_cnt,
  output logic [$clog2(depth):0]   rx_cnt,
  output logic                     rx_ovrflw,
  output logic                     pop_err
);
  localparam int cw = $clog2(depth) + 1;
  localparam logic [cw-1:0] full_cnt = cw'(depth);

  logic rdy_en;   // low from reset until the first edge with reset released
  logic tx_full;
  logic rx_full;
  logic tx_wr;
  logic tx_rd;
  logic rx_hit;   // push that passes address filtering
  logic rx_wr;
  logic rx_rd;
  logic id_ok;

`ifdef PRLL_BS_RX_ID_FILTER_EN
  logic [7:0] dst;
  assign dst   = D_push[bits-1 -: 8];
  assign id_ok = (dst == id) || (dst == broadcast);
`else
  assign id_ok = 1'b1;
`endif

  // Status is derived from registered counts only, so pop/push never reach
  // an output combinationally.
  assign tx_full = (tx_cnt == full_cnt);
  assign rx_full = (rx_cnt == full_cnt);
  assign tx_rdy  = rdy_en && !tx_full;
  assign pndng   = (tx_cnt != '0);
  assign rx_vld  = (rx_cnt != '0);

  assign tx_wr  = tx_vld && tx_rdy;
  assign tx_rd  = pop && pndng;
  assign rx_hit = push && id_ok;
  // Fullness uses the pre-edge count: a same-cycle RX read does not make room.
  assign rx_wr  = rx_hit && !rx_full;
  assign rx_rd  = rx_vld && rx_rdy;

  prll_bs_fifo #(.bits(bits), .depth(depth)) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr      (tx_wr),
    .wr_data (tx_data),
    .rd      (tx_rd),
    .head    (D_pop),
    .cnt     (tx_cnt)
  );

  prll_bs_fifo #(.bits(bits), .depth(depth)) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr      (rx_wr),
    .wr_data (D_push),
    .rd      (rx_rd),
    .head    (rx_data),
    .cnt     (rx_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rdy_en    <= 1'b0;
      rx_ovrflw <= 1'b0;
      pop_err   <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (rx_hit && rx_full) rx_ovrflw <= 1'b1;
      if (pop && !pndng)     pop_err   <= 1'b1;
    end
  end
endmodule
